// File: rtl/arc4_param_core_if.sv
// Handshake, key and memory-port bundle for arc4_param_core.
// The master side supplies start/key and services both memories; the core is the slave.
interface arc4_param_core_if #(
    parameter int KEY_BYTES = 3
);
    logic                   en;
    logic                   rdy;
    logic [8*KEY_BYTES-1:0] key;
    logic [7:0]             ct_addr;
    logic [7:0]             ct_rddata;
    logic [7:0]             pt_addr;
    logic [7:0]             pt_wrdata;
    logic                   pt_wren;
    logic                   err;

    modport master (
        output en, key, ct_rddata,
        input  rdy, ct_addr, pt_addr, pt_wrdata, pt_wren, err
    );

    modport slave (
        input  en, key, ct_rddata,
        output rdy, ct_addr, pt_addr, pt_wrdata, pt_wren, err
    );
endinterface

// File: rtl/arc4_param_core.sv
// RC4 decryptor: length-prefixed ciphertext in, length-prefixed plaintext out.
// One S-box swap per cycle for key scheduling and two cycles per output byte.
module arc4_param_core #(
    parameter int KEY_BYTES = 3,
    parameter int LEN_BITS  = 8
) (
    input  logic             clk,
    input  logic             rst,
    arc4_param_core_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, INIT, KSA, LEN_RD, LEN_WR, PRGA_A, PRGA_B, DONE
    } state_t;

    localparam int KW = 8 * KEY_BYTES;

    state_t              state_r, state_s;
    logic [7:0]          s_r [256];
    logic [7:0]          i_r, i_s, j_r, j_s;
    logic [LEN_BITS-1:0] k_r, k_s, len_r, len_s;
    logic [KW-1:0]       key_r;
    logic                rdy_r, err_r, err_s, pt_wren_r;
    logic [7:0]          ct_addr_r, pt_addr_r;
    logic                init_wr_s, swap_s;
    logic [7:0]          swap_a_s, swap_b_s;
    logic [7:0]          key_byte_s, ks_idx_s, pt_wrdata_s;

    // The key register rotates left one byte per KSA cycle, so its top byte
    // always holds keybyte[i mod KEY_BYTES] without a separate modulo counter.
    assign key_byte_s = key_r[KW-1 -: 8];
    assign ks_idx_s   = s_r[i_r] + s_r[j_r];

    assign bus.rdy       = rdy_r;
    assign bus.err       = err_r;
    assign bus.ct_addr   = ct_addr_r;
    assign bus.pt_addr   = pt_addr_r;
    assign bus.pt_wren   = pt_wren_r;
    assign bus.pt_wrdata = pt_wrdata_s;

    // Next-state, index updates, S-box write requests and plaintext data.
    always_comb begin
        state_s     = state_r;
        i_s         = i_r;
        j_s         = j_r;
        k_s         = k_r;
        len_s       = len_r;
        err_s       = err_r;
        init_wr_s   = 1'b0;
        swap_s      = 1'b0;
        swap_a_s    = i_r;
        swap_b_s    = j_r;
        pt_wrdata_s = 8'h00;
        case (state_r)
            IDLE: begin
                if (bus.en) begin
                    state_s = INIT;
                    i_s     = 8'h00;
                    j_s     = 8'h00;
                    k_s     = {LEN_BITS{1'b0}};
                    err_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            INIT: begin
                init_wr_s = 1'b1;
                i_s       = i_r + 8'd1;
                if (i_r == 8'hFF) begin
                    state_s = KSA;
                end else begin
                    state_s = INIT;
                end
            end
            KSA: begin
                j_s      = j_r + s_r[i_r] + key_byte_s;
                swap_s   = 1'b1;
                swap_a_s = i_r;
                swap_b_s = j_s;
                i_s      = i_r + 8'd1;
                if (i_r == 8'hFF) begin
                    state_s = LEN_RD;
                end else begin
                    state_s = KSA;
                end
            end
            LEN_RD: begin
                state_s = LEN_WR;
            end
            LEN_WR: begin
                len_s       = LEN_BITS'(bus.ct_rddata);
                pt_wrdata_s = bus.ct_rddata;
                i_s         = 8'h00;
                j_s         = 8'h00;
                k_s         = LEN_BITS'(1);
                if (bus.ct_rddata == 8'h00) begin
                    err_s   = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = PRGA_A;
                end
            end
            PRGA_A: begin
                i_s      = i_r + 8'd1;
                j_s      = j_r + s_r[i_s];
                swap_s   = 1'b1;
                swap_a_s = i_s;
                swap_b_s = j_s;
                state_s  = PRGA_B;
            end
            PRGA_B: begin
                pt_wrdata_s = bus.ct_rddata ^ s_r[ks_idx_s];
                if (k_r == len_r) begin
                    state_s = DONE;
                end else begin
                    k_s     = k_r + LEN_BITS'(1);
                    state_s = PRGA_A;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control state and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            i_r       <= 8'h00;
            j_r       <= 8'h00;
            k_r       <= {LEN_BITS{1'b0}};
            len_r     <= {LEN_BITS{1'b0}};
            key_r     <= {KW{1'b0}};
            rdy_r     <= 1'b1;
            err_r     <= 1'b0;
            pt_wren_r <= 1'b0;
            ct_addr_r <= 8'h00;
            pt_addr_r <= 8'h00;
        end else begin
            state_r   <= state_s;
            i_r       <= i_s;
            j_r       <= j_s;
            k_r       <= k_s;
            len_r     <= len_s;
            err_r     <= err_s;
            rdy_r     <= (state_s == IDLE);
            pt_wren_r <= (state_s == LEN_WR) || (state_s == PRGA_B);
            ct_addr_r <= (state_s == PRGA_A) ? 8'(k_s) : 8'h00;
            pt_addr_r <= (state_s == PRGA_B) ? 8'(k_s) : 8'h00;
            if (state_r == IDLE && bus.en) begin
                key_r <= bus.key;
            end else if (state_r == KSA) begin
                key_r <= KW'({key_r, key_r} >> (KW - 8));
            end
        end
    end

    // S-box storage: fill in INIT, dual-write swap in KSA/PRGA_A; never reset.
    always_ff @(posedge clk) begin
        if (!rst && init_wr_s) begin
            s_r[i_r] <= i_r;
        end else if (!rst && swap_s) begin
            s_r[swap_a_s] <= s_r[swap_b_s];
            s_r[swap_b_s] <= s_r[swap_a_s];
        end
    end
endmodule

// File: doc/arc4_param_core.md
ARC4_PARAM_CORE -- requirements
Module: arc4_param_core

Interface
REQ-001 Parameter KEY_BYTES, default 3: key length in bytes, legal range 1..16.
REQ-002 Parameter LEN_BITS, default 8: width of the length prefix and the message addresses, legal range 8 only in this revision.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  start request; sampled only while rdy=1.
REQ-006 rdy  output  1  1 = idle and able to accept en.
REQ-007 key  input  8*KEY_BYTES  key; key[8*KEY_BYTES-1 -: 8] is key byte 0 (big-endian); captured on the accept cycle.
REQ-008 ct_addr  output  8  ciphertext memory read address.
REQ-009 ct_rddata  input  8  ciphertext read data; synchronous memory, valid one cycle after ct_addr.
REQ-010 pt_addr  output  8  plaintext memory write address.
REQ-011 pt_wrdata  output  8  plaintext write data.
REQ-012 pt_wren  output  1  plaintext write strobe, one cycle per byte.
REQ-013 err  output  1  sticky: set when the length prefix is 0; cleared on the next accepted en.

Function
REQ-014 Handshake: en=1 with rdy=1 on a rising edge is accepted; rdy=0 from the next cycle until completion; en while rdy=0 is ignored.
REQ-015 Internal state array S: 256x8 registers, combinational read, up to two writes per cycle; indices i, j, k are 8-bit and wrap modulo 256.
REQ-016 FSM states: IDLE, INIT, KSA, LEN_RD, LEN_WR, PRGA_A, PRGA_B, DONE.
REQ-017 INIT: 256 cycles; cycle n writes S[n]=n.
REQ-018 KSA: 256 cycles; cycle i computes j = j + S[i] + keybyte[i mod KEY_BYTES] (mod 256) and swaps S[i], S[j] in the same cycle; j starts at 0.
REQ-019 LEN_RD drives ct_addr=0. LEN_WR captures L=ct_rddata, writes pt[0]=L with pt_wren=1, and resets i=j=0.
REQ-020 If L=0, LEN_WR still writes pt[0]=0, sets err=1 and goes to DONE.
REQ-021 PRGA_A, byte k=1..L: drive ct_addr=k; i=i+1; j=j+S[i]; swap S[i], S[j].
REQ-022 PRGA_B, byte k: pt_addr=k; pt_wrdata = ct_rddata XOR S[(S[i]+S[j]) mod 256], computed on the post-swap S; pt_wren=1.
REQ-023 After PRGA_B for k=L go to DONE; otherwise return to PRGA_A for k+1.
REQ-024 DONE lasts one cycle, then IDLE with rdy=1.
REQ-025 Latency: rdy is low for exactly 515+2L cycles (L>=1), or 515 cycles when L=0.
REQ-026 pt_wren is 0 in every state except LEN_WR and PRGA_B.
REQ-027 ct_addr and pt_addr are 0 in all other states.
REQ-028 L=255: k reaches 255 with no wrap, and 255 bytes are written.
REQ-029 KEY_BYTES not dividing 256: key index wraps mod KEY_BYTES independent of i.
REQ-030 A change on key after acceptance has no effect on the current run.

Reset
REQ-031 rst=1 on an edge forces, in the next cycle: state=IDLE, rdy=1, err=0, pt_wren=0, ct_addr=0, pt_addr=0, pt_wrdata=0, i=j=k=0.
REQ-032 S contents are not reset.
REQ-033 rst has priority over en in the same cycle.
REQ-034 rst mid-operation aborts at once; no further pt writes occur.
REQ-035 After rst deasserts, a fresh en restarts from INIT.

Verification
REQ-036 KEY_BYTES=3, key=0x4B6579 ("Key"), ct = 09 BB F3 16 E8 D9 40 AF 0A D3 -> pt = 09 "Plaintext" (50 6C 61 69 6E 74 65 78 74); rdy low for 533 cycles; err=0.
REQ-037 KEY_BYTES=4, key=0x57696B69 ("Wiki"), ct = 05 10 21 BF 04 20 -> pt = 05 "pedia"; exactly 6 pt_wren pulses.
REQ-038 KEY_BYTES=6, key "Secret", ct = 0E 45 A0 1F 64 5F C3 5B 38 35 52 54 4B 9B F5 -> pt = 0E "Attack at dawn".
REQ-039 ct[0]=00 -> single write pt[0]=00, err=1, rdy low for 515 cycles; next accepted run clears err.
REQ-040 Assert rst during PRGA_A at k=3 -> rdy=1 next cycle, no further pt_wren; a rerun with the REQ-036 vector produces the correct pt.
REQ-041 Pulse en while rdy=0 -> ignored: no restart, and the total latency is unchanged.
